// File: rtl/memory_access_pkg.sv
// mem_pkg: shared memory-stage types and constants.
package mem_pkg;
  typedef logic [0:0] mem_state_e;
  localparam mem_state_e IDLE = 1'b0;
  localparam mem_state_e WAIT = 1'b1;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } w_ctrl_t;
  localparam logic [4:0] RA_REG = 5'd31;
endpackage

// File: rtl/memory_access_writeback_reg.sv
// writeback_reg: W pipeline register; a bubble clears control and holds data.
module writeback_reg
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bubble_i,
  input  logic        ld_rdata_i,
  input  w_ctrl_t     ctrl_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rdata_i,
  input  logic [4:0]  write_reg_i,
  output w_ctrl_t     ctrl_o,
  output logic [31:0] alu_out_o,
  output logic [31:0] read_data_o,
  output logic [4:0]  write_reg_o
);
  w_ctrl_t     ctrl_q;
  logic [31:0] alu_out_q, read_data_q;
  logic [4:0]  write_reg_q;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q      <= '0;
      alu_out_q   <= '0;
      read_data_q <= '0;
      write_reg_q <= '0;
    end else if (bubble_i) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q      <= ctrl_i;
      alu_out_q   <= alu_out_i;
      write_reg_q <= write_reg_i;
      if (ld_rdata_i) read_data_q <= rdata_i;
    end
  end
  assign ctrl_o      = ctrl_q;
  assign alu_out_o   = alu_out_q;
  assign read_data_o = read_data_q;
  assign write_reg_o = write_reg_q;
endmodule

// File: rtl/memory_access.sv
// memory_access: MIPS M stage; data-memory access over valid/ready with
// timeout abort, stall generation and the W pipeline register.
module memory_access
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_write_m_i,
  input  logic              mem_write_m_i,
  input  logic              mem_to_reg_m_i,
  input  logic [31:0]       alu_out_m_i,
  input  logic [31:0]       write_data_m_i,
  input  logic [4:0]        write_reg_m_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              stall_m_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              reg_write_w_o,
  output logic              mem_to_reg_w_o,
  output logic [31:0]       read_data_w_o,
  output logic [31:0]       alu_out_w_o,
  output logic [4:0]        write_reg_w_o,
  output logic [31:0]       result_w_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q;
  logic          idle, mem_op, aligned, done, timeout;
  w_ctrl_t       ctrl_m, ctrl_w;
  assign idle       = (state_q == IDLE);
  assign mem_op     = mem_write_m_i | mem_to_reg_m_i;
  assign aligned    = (alu_out_m_i[1:0] == 2'b00);
  assign misalign_o = mem_op & ~aligned;
  // Upstream is frozen while waiting, so the M inputs stay valid in WAIT.
  assign dmem_req_o   = idle ? mem_op & aligned : 1'b1;
  assign dmem_we_o    = dmem_req_o & mem_write_m_i;
  assign dmem_addr_o  = alu_out_m_i[ADDR_W-1:0];
  assign dmem_wdata_o = write_data_m_i;
  assign done         = dmem_req_o & dmem_ready_i;
  assign timeout      = ~idle & ~dmem_ready_i & (cnt_q == CW'(MAX_WAIT - 1));
  assign stall_m_o    = dmem_req_o & ~dmem_ready_i & ~timeout;
  assign state_d      = stall_m_o ? WAIT : IDLE;
  assign cnt_d        = (stall_m_o & ~idle) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= timeout;
    end
  end
  assign bus_err_o = bus_err_q;
  assign ctrl_m = '{reg_write: reg_write_m_i & ~misalign_o, mem_to_reg: mem_to_reg_m_i};
  writeback_reg u_wb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bubble_i    (stall_m_o | timeout),
    .ld_rdata_i  (done & mem_to_reg_m_i),
    .ctrl_i      (ctrl_m),
    .alu_out_i   (alu_out_m_i),
    .rdata_i     (dmem_rdata_i),
    .write_reg_i (write_reg_m_i),
    .ctrl_o      (ctrl_w),
    .alu_out_o   (alu_out_w_o),
    .read_data_o (read_data_w_o),
    .write_reg_o (write_reg_w_o)
  );
  assign reg_write_w_o  = ctrl_w.reg_write;
  assign mem_to_reg_w_o = ctrl_w.mem_to_reg;
  assign result_w_o     = ctrl_w.mem_to_reg ? read_data_w_o : alu_out_w_o;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized instruction stream against a transaction-level
// model of the memory stage, plus directed cases with literal expectations.
module tb_memory_access;
  localparam int MW = 4;
  logic        clk, rst;
  logic        reg_write_m, mem_write_m, mem_to_reg_m;
  logic [31:0] alu_out_m, write_data_m, dmem_rdata;
  logic [4:0]  write_reg_m;
  logic        dmem_ready;
  logic        dmem_req_o, dmem_we_o, stall_m_o, misalign_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        reg_write_w_o, mem_to_reg_w_o;
  logic [31:0] read_data_w_o, alu_out_w_o, result_w_o;
  logic [4:0]  write_reg_w_o;

  memory_access #(.MAX_WAIT(MW), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_write_m_i(reg_write_m), .mem_write_m_i(mem_write_m), .mem_to_reg_m_i(mem_to_reg_m),
    .alu_out_m_i(alu_out_m), .write_data_m_i(write_data_m), .write_reg_m_i(write_reg_m),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready), .dmem_rdata_i(dmem_rdata),
    .stall_m_o(stall_m_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .reg_write_w_o(reg_write_w_o), .mem_to_reg_w_o(mem_to_reg_w_o),
    .read_data_w_o(read_data_w_o), .alu_out_w_o(alu_out_w_o),
    .write_reg_w_o(write_reg_w_o), .result_w_o(result_w_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, fails = 0, err_seen = 0;
  bit chk_en = 0;
  // Expected values for the current cycle (comb) and the W register contents.
  bit          e_req, e_we, e_stall, e_mis, e_err, pend;
  logic [31:0] e_addr, e_wd;
  bit          w_rw, w_m2r;
  logic [31:0] w_rd, w_alu;
  logic [4:0]  w_wr;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    if (bus_err_o === 1'b1) err_seen++;
    chk("req", 32'(dmem_req_o), 32'(e_req));
    chk("stall", 32'(stall_m_o), 32'(e_stall));
    chk("misalign", 32'(misalign_o), 32'(e_mis));
    chk("bus_err", 32'(bus_err_o), 32'(e_err));
    if (e_req) begin
      chk("we", 32'(dmem_we_o), 32'(e_we));
      chk("addr", dmem_addr_o, e_addr);
      chk("wdata", dmem_wdata_o, e_wd);
    end
    chk("rw_w", 32'(reg_write_w_o), 32'(w_rw));
    chk("m2r_w", 32'(mem_to_reg_w_o), 32'(w_m2r));
    chk("rd_w", read_data_w_o, w_rd);
    chk("alu_w", alu_out_w_o, w_alu);
    chk("wr_w", 32'(write_reg_w_o), 32'(w_wr));
    chk("result_w", result_w_o, w_m2r ? w_rd : w_alu);
  end

  // One instruction's residency in M: ready arrives n cycles after it enters
  // (n > MW never completes); rst_k is the residency cycle to assert reset on.
  task automatic run(input bit rw, input bit mw, input bit m2r, input logic [31:0] alu,
                     input logic [31:0] wd, input logic [4:0] wr, input int n, input int rst_k,
                     input bit rnd_rd, input logic [31:0] rdv, output int stalls, output int reqs);
    bit mem, mis, go, to;
    mem = mw | m2r;
    mis = mem && alu[1:0] != 2'b00;
    stalls = 0;
    reqs = 0;
    for (int k = 0; k <= MW; k++) begin
      reg_write_m = rw; mem_write_m = mw; mem_to_reg_m = m2r;
      alu_out_m = alu; write_data_m = wd; write_reg_m = wr;
      dmem_rdata = rnd_rd ? $urandom : rdv;
      if (mem && !mis) begin
        dmem_ready = (k == n);
        go = dmem_ready;
        to = (k == MW) && !go;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        go = 1;
        to = 0;
      end
      rst = !(k == rst_k);
      e_req = mem && !mis; e_we = mw; e_addr = alu; e_wd = wd;
      e_stall = !go && !to; e_mis = mis; e_err = pend;
      @(negedge clk);
      stalls += int'(stall_m_o);
      reqs += int'(dmem_req_o);
      @(posedge clk);
      #1;
      pend = to;
      if (k == rst_k) begin
        w_rw = 0; w_m2r = 0; w_rd = '0; w_alu = '0; w_wr = '0; pend = 0; rst = 1;
        return;
      end
      if (go) begin
        w_rw = rw && !mis; w_m2r = m2r; w_alu = alu; w_wr = wr;
        if (m2r && e_req) w_rd = dmem_rdata;
      end else begin
        w_rw = 0; w_m2r = 0;
      end
      if (go || to) return;
    end
  endtask

  initial begin
    int s, r, e0;
    rst = 0; reg_write_m = 0; mem_write_m = 0; mem_to_reg_m = 0;
    alu_out_m = '0; write_data_m = '0; write_reg_m = '0; dmem_ready = 0; dmem_rdata = '0;
    pend = 0; e_req = 0; e_we = 0; e_stall = 0; e_mis = 0; e_err = 0; e_addr = '0; e_wd = '0;
    w_rw = 0; w_m2r = 0; w_rd = '0; w_alu = '0; w_wr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("reset_rw", 32'(reg_write_w_o), 32'd0);
    chk("reset_result", result_w_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1;
    // ALU op
    run(1, 0, 0, 32'h0000_1234, 32'h0, 5'd8, 0, -1, 1, 32'h0, s, r);
    chk("t1_result", result_w_o, 32'h0000_1234);
    chk("t1_rw", 32'(reg_write_w_o), 32'd1);
    chk("t1_stall", s, 0);
    // zero-wait load
    run(1, 0, 1, 32'h100, 32'h0, 5'd9, 0, -1, 0, 32'hDEAD_BEEF, s, r);
    chk("t2_result", result_w_o, 32'hDEAD_BEEF);
    chk("t2_wr", 32'(write_reg_w_o), 32'd9);
    chk("t2_stall", s, 0);
    chk("t2_reqs", r, 1);
    // 3-wait store
    run(0, 1, 0, 32'h40, 32'hCAFE, 5'd3, 3, -1, 1, 32'h0, s, r);
    chk("t3_stall", s, 3);
    chk("t3_reqs", r, 4);
    chk("t3_rw", 32'(reg_write_w_o), 32'd0);
    chk("t3_rd_held", read_data_w_o, 32'hDEAD_BEEF);
    // timeout, then a normal ALU op
    e0 = err_seen;
    run(1, 0, 1, 32'h200, 32'h0, 5'd4, 99, -1, 1, 32'h0, s, r);
    chk("t4_stall", s, MW);
    chk("t4_rw", 32'(reg_write_w_o), 32'd0);
    run(1, 0, 0, 32'h55, 32'h0, 5'd5, 0, -1, 1, 32'h0, s, r);
    chk("t4_err_pulses", err_seen - e0, 1);
    chk("t4_after_result", result_w_o, 32'h55);
    chk("t4_after_stall", s, 0);
    // misaligned load
    run(1, 0, 1, 32'h102, 32'h0, 5'd7, 0, -1, 1, 32'h0, s, r);
    chk("t5_reqs", r, 0);
    chk("t5_stall", s, 0);
    chk("t5_rw", 32'(reg_write_w_o), 32'd0);
    // reset during WAIT
    run(1, 0, 1, 32'h300, 32'h0, 5'd6, 99, 2, 1, 32'h0, s, r);
    chk("t6_alu", alu_out_w_o, 32'd0);
    chk("t6_wr", 32'(write_reg_w_o), 32'd0);
    chk("t6_rw", 32'(reg_write_w_o), 32'd0);
    run(1, 0, 0, 32'h77, 32'h0, 5'd10, 0, -1, 1, 32'h0, s, r);
    chk("t6_after_stall", s, 0);
    // random instruction stream
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run(1'($urandom_range(0, 1)), op == 2, op == 1, a, $urandom, 5'($urandom),
          $urandom_range(0, MW + 2), -1, 1, 32'h0, s, r);
    end
    run(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, -1, 1, 32'h0, s, r);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
Memory pipeline stage of the 5-stage MIPS core. It consumes the execute stage's M-side outputs (control bits, ALU result, store data, destination register) and performs the data-memory access over a valid/ready bus. It raises a pipeline stall while a request is outstanding. Its writeback pipeline register produces the W-stage signals, including result_w, which feeds back to execute forwarding.

Parameters:
MAX_WAIT, 16, maximum cycles spent waiting for dmem_ready_i before the access is aborted (≥1)
ADDR_W, 32, data bus address width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-low
reg_write_m_i  input  1  M-stage register-write enable
mem_write_m_i  input  1  M-stage store
mem_to_reg_m_i  input  1  M-stage load (result from memory)
alu_out_m_i  input  32  effective address / ALU result
write_data_m_i  input  32  store data
write_reg_m_i  input  5  destination register
dmem_req_o  output  1  bus request valid
dmem_we_o  output  1  1 = write, 0 = read
dmem_addr_o  output  ADDR_W  word address (= alu_out_m_i)
dmem_wdata_o  output  32  store data
dmem_ready_i  input  1  bus completes the access this cycle
dmem_rdata_i  input  32  load data, valid when dmem_ready_i=1
stall_m_o  output  1  freeze F/D/E/M pipeline registers
misalign_o  output  1  memory op with alu_out_m_i[1:0] != 0 (this cycle)
bus_err_o  output  1  one-cycle pulse on timeout abort
reg_write_w_o  output  1  W-stage register-write enable
mem_to_reg_w_o  output  1  W-stage select
read_data_w_o  output  32  registered load data
alu_out_w_o  output  32  registered ALU result
write_reg_w_o  output  5  W-stage destination
result_w_o  output  32  mem_to_reg_w_o ? read_data_w_o : alu_out_w_o

Behaviour:
- mem_op = mem_write_m_i | mem_to_reg_m_i; aligned = (alu_out_m_i[1:0] == 0).
- Reset (rst_i=0 at an edge):
  - State goes to IDLE and the wait counter to 0.
  - bus_err_o, reg_write_w_o and mem_to_reg_w_o go to 0.
  - read_data_w_o, alu_out_w_o and write_reg_w_o go to 0.
  - Reset overrides any outstanding request; the bus is required to drop it.
- FSM states: IDLE, WAIT.
- IDLE, no mem_op: dmem_req_o=0, stall_m_o=0. The W register captures the M inputs next edge.
- IDLE, mem_op & aligned:
  - dmem_req_o=1 combinationally, with dmem_we_o=mem_write_m_i and address/data from the inputs.
  - If dmem_ready_i=1 the same cycle: zero-wait completion, stall_m_o=0, W captures M inputs plus dmem_rdata_i.
  - Otherwise stall_m_o=1, counter is cleared, next state is WAIT.
- WAIT:
  - dmem_req_o stays 1. Inputs are stable because upstream is frozen by the stall.
  - stall_m_o = !dmem_ready_i.
  - On dmem_ready_i: W captures the access, next state is IDLE.
  - Otherwise the counter increments.
- Timeout: in WAIT with counter == MAX_WAIT-1 and no ready:
  - bus_err_o=1 the next cycle (one cycle only).
  - stall_m_o=0 this cycle, W loads a bubble, next state is IDLE.
  - A late dmem_ready_i in IDLE is ignored.
- Misaligned mem_op:
  - No request; misalign_o=1 combinationally; stall_m_o=0.
  - W captures with reg_write_w_o forced to 0. A misaligned store never reaches the bus.
- Bubble rule: on any edge where stall_m_o=1, the W register loads reg_write=0, mem_to_reg=0 and holds its data fields. No instruction is written back twice.
- dmem_ready_i with dmem_req_o=0 has no effect.
- The store path does not update read_data_w_o (it holds its value).
- Latency:
  - Non-memory op: 1 cycle M→W.
  - Memory op: 1 + N cycles for N wait states; stall_m_o is asserted for exactly N cycles.
- Counter width: $clog2(MAX_WAIT+1); the counter never wraps.

Decomposition:
- Shared package mem_pkg: mem_state_e {IDLE, WAIT}; W-control struct {reg_write, mem_to_reg}; constant RA_REG=5'd31 reused by the core.
- One sub-module, writeback_reg: W pipeline register with a bubble input and synchronous active-low reset. It mirrors the existing memory_reg.

Test Plan:
1. ALU op: reg_write=1, alu_out=32'h0000_1234, write_reg=5'd8, no mem_op → after 1 edge reg_write_w_o=1, result_w_o=32'h1234, stall never asserts.
2. Zero-wait load: addr 32'h100, dmem_ready_i=1 same cycle with rdata 32'hDEAD_BEEF → stall_m_o=0, next cycle result_w_o=32'hDEADBEEF, write_reg_w_o matches.
3. 3-wait store: addr 32'h40, data 32'hCAFE, ready on 4th cycle → dmem_req_o/we high 4 cycles, stall_m_o high exactly 3, W shows bubbles during stall, then reg_write_w_o=0.
4. Timeout with MAX_WAIT=4, ready never asserted → stall high 4 cycles, bus_err_o pulses once, FSM back to IDLE, a following ALU op writes back normally.
5. Misaligned load at 32'h102 → misalign_o=1, dmem_req_o=0, stall_m_o=0, reg_write_w_o=0 next cycle.
6. Reset (rst_i=0) during WAIT → next cycle stall_m_o=0, dmem_req_o=0, all W outputs 0.
